simplez_uart_tx: RTL and testbench

Memory-mapped serial transmitter for the Simplez microcontroller. It answers the processor's external bus (RA, esc, lec, busD) as a bus responder, alongside the main memory and the LED port. A store to its data address launches one 8N1 frame on `tx`. A load from its status address returns ready and overrun flags, so programs can poll before writing.

---
 rtl/simplez_uart_tx.sv | 128 ++++++++++++
 tb/tb_simplez_uart_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 serial transmitter for the Simplez external bus.
// A store to ADDR_DATA starts a frame. A load from ADDR_STAT returns {overrun, ready}.
module simplez_uart_tx #(
    parameter int               ADDRW     = 9,
    parameter int               DATAW     = 12,
    parameter int               BAUD_DIV  = 104,
    parameter logic [ADDRW-1:0] ADDR_DATA = 9'o101,
    parameter logic [ADDRW-1:0] ADDR_STAT = 9'o102
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ADDRW-1:0] addr,
    input  logic             wr,
    input  logic             rd,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             sel,
    output logic             tx,
    output logic             busy
);
    localparam int              CNTW        = 12;
    localparam logic [CNTW-1:0] BAUD_RELOAD = CNTW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nxt;
    logic [7:0]      shift_q, shift_nxt;
    logic [CNTW-1:0] cnt_q, cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic            tx_nxt, busy_nxt;
    logic            overrun, overrun_nxt;
    logic            sel_nxt;
    logic [DATAW-1:0] data_out_nxt;

    logic wr_data, rd_stat, bit_end;
    logic unused_bits;

    assign wr_data     = wr && (addr == ADDR_DATA);
    assign rd_stat     = rd && (addr == ADDR_STAT);
    assign bit_end     = (cnt_q == '0);
    assign unused_bits = ^data_in[DATAW-1:8];

    always_ff @(negedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            sel      <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nxt;
            shift_q  <= shift_nxt;
            cnt_q    <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            overrun  <= overrun_nxt;
            sel      <= sel_nxt;
            data_out <= data_out_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        cnt_nxt     = cnt_q;
        bit_idx_nxt = bit_idx;
        tx_nxt      = tx;
        busy_nxt    = busy;

        if (state != IDLE)
            cnt_nxt = bit_end ? BAUD_RELOAD : cnt_q - 1'b1;

        case (state)
            IDLE: begin
                if (wr_data) begin
                    shift_nxt = data_in[7:0];
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = BAUD_RELOAD;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    tx_nxt      = shift_q[0];
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_q >> 1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        // shift_q[1] is the bit that lands in [0] after this shift
                        tx_nxt      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A dropped write wins over a simultaneous status-read clear.
    always_comb begin
        overrun_nxt = overrun;
        if (wr_data && state != IDLE)
            overrun_nxt = 1'b1;
        else if (rd_stat)
            overrun_nxt = 1'b0;
        sel_nxt      = rd_stat;
        data_out_nxt = rd_stat ? DATAW'({overrun, ~busy}) : '0;
    end
endmodule

// File: tb/tb_simplez_uart_tx.sv
// Bench for simplez_uart_tx: directed vectors, corner sequences and random traffic
// checked against a frame-timing reference model.
module tb_simplez_uart_tx;
    localparam int         B     = 4;
    localparam logic [8:0] A_DAT = 9'o101;
    localparam logic [8:0] A_STA = 9'o102;
    localparam logic [8:0] A_OTH = 9'o100;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [8:0]  addr = '0;
    logic        wr = 1'b0, rd = 1'b0;
    logic [11:0] data_in = '0;
    logic [11:0] data_out;
    logic        sel, tx, busy;

    int tests = 0, fails = 0;

    // reference model state
    bit          m_active = 0;
    int          m_t = 0;
    logic [7:0]  m_byte = '0;
    bit          m_ovr = 0;
    logic [11:0] m_dout = '0;
    bit          m_sel = 0;

    simplez_uart_tx #(.ADDRW(9), .DATAW(12), .BAUD_DIV(B),
                      .ADDR_DATA(9'o101), .ADDR_STAT(9'o102)) dut (
        .clk(clk), .rstn(rstn), .addr(addr), .wr(wr), .rd(rd),
        .data_in(data_in), .data_out(data_out), .sel(sel), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Expected line level from elapsed cycles since accept: start, 8 data LSB first, stop.
    function automatic logic m_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / B;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic w, input logic r, input logic [8:0] a,
                              input logic [11:0] d, input logic rn);
        bit pre_busy, hit;
        if (!rn) begin
            m_active = 0; m_t = 0; m_ovr = 0; m_dout = '0; m_sel = 0;
        end else begin
            pre_busy = m_active;
            m_sel    = r && (a == A_STA);
            m_dout   = m_sel ? {10'b0, m_ovr, ~pre_busy} : 12'h000;
            hit      = 0;
            if (m_active) begin
                m_t++;
                if (m_t >= 10 * B) m_active = 0;
            end
            if (w && a == A_DAT) begin
                if (pre_busy) hit = 1;
                else begin m_active = 1; m_t = 0; m_byte = d[7:0]; end
            end
            m_ovr = hit ? 1'b1 : (m_sel ? 1'b0 : m_ovr);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [8:0] a,
                        input logic [11:0] d, input logic rn);
        wr = w; rd = r; addr = a; data_in = d; rstn = rn;
        @(negedge clk);
        model_edge(w, r, a, d, rn);
        #1;
        check("tx", {11'b0, tx}, {11'b0, m_tx()});
        check("busy", {11'b0, busy}, {11'b0, m_active});
        check("data_out", data_out, m_dout);
        check("sel", {11'b0, sel}, {11'b0, m_sel});
    endtask

    task automatic nop();
        step(1'b0, 1'b0, A_OTH, 12'h000, 1'b1);
    endtask

    typedef struct {
        logic        wr, rd;
        logic [8:0]  addr;
        logic [11:0] data;
        logic [11:0] exp_dout;
        logic        exp_sel, exp_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 1'b1, A_STA, 12'h000, 12'h001, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, A_DAT, 12'h000, 12'h000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, A_STA, 12'h0FF, 12'h000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, A_OTH, 12'h055, 12'h000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, A_OTH, 12'h000, 12'h000, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, A_STA, 12'h0AA, 12'h001, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, A_DAT, 12'h000, 12'h000, 1'b0, 1'b0};

        // reset held with a pending write: nothing starts
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, A_DAT, 12'h0FF, 1'b0);
            check("rst_tx", {11'b0, tx}, 12'h001);
            check("rst_busy", {11'b0, busy}, 12'h000);
            check("rst_dout", data_out, 12'h000);
            check("rst_sel", {11'b0, sel}, 12'h000);
        end

        // decode table from idle
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, 1'b1);
            check("vec_dout", data_out, vecs[i].exp_dout);
            check("vec_sel", {11'b0, sel}, {11'b0, vecs[i].exp_sel});
            check("vec_busy", {11'b0, busy}, {11'b0, vecs[i].exp_busy});
            check("vec_tx", {11'b0, tx}, 12'h001);
        end

        // single frame 0x55 with status reads and a mid-frame overrun write
        step(1'b1, 1'b0, A_DAT, 12'hF55, 1'b1);
        check("frame_tx0", {11'b0, tx}, 12'h000);
        for (int t = 1; t < 10 * B; t++) begin
            step(t == 10, (t == 5 || t == 20 || t == 21), (t == 10) ? A_DAT : A_STA, 12'h0AA, 1'b1);
            check("frame_tx", {11'b0, tx}, 12'((t / B) % 2));
            check("frame_busy", {11'b0, busy}, 12'h001);
            if (t == 5)  begin check("stat_busy", data_out, 12'h000); check("stat_sel", {11'b0, sel}, 12'h001); end
            if (t == 20) check("stat_ovr", data_out, 12'h002);
            if (t == 21) check("stat_ovr_clr", data_out, 12'h000);
        end
        nop();
        check("frame_end_busy", {11'b0, busy}, 12'h000);
        check("frame_end_tx", {11'b0, tx}, 12'h001);
        step(1'b0, 1'b1, A_STA, 12'h000, 1'b1);
        check("stat_ready", data_out, 12'h001);

        // back-to-back: one idle cycle, then the second frame starts
        step(1'b1, 1'b0, A_DAT, 12'h001, 1'b1);
        for (int t = 1; t < 10 * B; t++) nop();
        nop();
        check("gap_tx", {11'b0, tx}, 12'h001);
        check("gap_busy", {11'b0, busy}, 12'h000);
        step(1'b1, 1'b0, A_DAT, 12'h080, 1'b1);
        check("b2b_tx", {11'b0, tx}, 12'h000);
        check("b2b_busy", {11'b0, busy}, 12'h001);
        // write on the final STOP edge is an overrun
        for (int t = 1; t < 10 * B; t++) nop();
        step(1'b1, 1'b0, A_DAT, 12'h033, 1'b1);
        check("last_stop_busy", {11'b0, busy}, 12'h000);
        check("last_stop_tx", {11'b0, tx}, 12'h001);
        step(1'b0, 1'b1, A_STA, 12'h000, 1'b1);
        check("last_stop_ovr", data_out, 12'h003);
        step(1'b0, 1'b1, A_STA, 12'h000, 1'b1);
        check("ovr_cleared", data_out, 12'h001);

        // reset during data bit 3
        step(1'b1, 1'b0, A_DAT, 12'h000, 1'b1);
        for (int t = 1; t <= 4 * B + 1; t++) nop();
        check("mid_tx_low", {11'b0, tx}, 12'h000);
        step(1'b0, 1'b0, A_OTH, 12'h000, 1'b0);
        check("abort_tx", {11'b0, tx}, 12'h001);
        check("abort_busy", {11'b0, busy}, 12'h000);
        step(1'b0, 1'b1, A_STA, 12'h000, 1'b1);
        check("abort_stat", data_out, 12'h001);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       w, r, rn;
            logic [8:0] a;
            int         pick;
            w    = ($urandom_range(0, 19) == 0);
            r    = ($urandom_range(0, 4) == 0);
            rn   = ($urandom_range(0, 299) != 0);
            pick = $urandom_range(0, 3);
            a    = (pick == 0) ? A_STA : (pick == 1) ? A_OTH : (pick == 2) ? A_DAT : 9'($urandom);
            if (w && $urandom_range(0, 1) == 0) a = A_DAT;
            step(w, r, a, 12'($urandom), rn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
